// File: rtl/display_scan_if.sv
// Write port bundle for the display_scan controller.
// The digit-entry side drives the request (master); the scan controller
// answers with ready and the illegal-write flag (slave).
interface display_scan_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_pos;
  logic [3:0] wr_dig;
  logic       wr_err;

  modport master (
    output wr_valid, wr_pos, wr_dig,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_pos, wr_dig,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed 8-digit seven-segment scan controller.
// One BCD register per digit, one shared active-low segment bus and
// eight active-low anodes. Each digit slot opens with a blanking gap
// (all anodes off) before the digit is lit, to avoid ghosting.
// Optional build macro DISPLAY_SCAN_LZ_BLANK_EN enables leading-zero
// blanking: digits 1..7 stay dark while they and every digit above are 0.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_BLANK | cnt < BLANK, all anodes off, any digit may be written
// ST_SHOW  | cnt >= BLANK, digit idx lit, writes to idx are stalled
module display_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic             clock,
  input  logic             reset,
  display_scan_if.slave    wr,
  output logic [7:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    digit_q [8];
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          err_q;
  logic          wr_fire;
  logic          wr_legal;
  logic          lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Slot counter advance; the scan index steps on the last cycle of a slot.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Next phase follows directly from where the counter lands.
  always_comb begin
    state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
  end

  // Phase, slot counter and scan index registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Write handshake: refuse only the digit that is currently lit.
  always_comb begin
    wr.wr_ready = !((state_q == ST_SHOW) && (wr.wr_pos == {1'b0, idx_q}));
    wr_fire     = wr.wr_valid && wr.wr_ready;
    wr_legal    = !wr.wr_pos[3] && (wr.wr_dig <= 4'd9);
  end

  // Digit storage; illegal transfers are swallowed and flagged one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= 4'd0;
      err_q <= 1'b0;
    end else begin
      if (wr_fire && wr_legal) digit_q[wr.wr_pos[2:0]] <= wr.wr_dig;
      err_q <= wr_fire && !wr_legal;
    end
  end

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
  logic [7:0] upper_zero;

  // upper_zero[i]: digit i and every digit above it hold 0.
  always_comb begin
    upper_zero    = '0;
    upper_zero[7] = (digit_q[7] == 4'd0);
    for (int i = 6; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (digit_q[i] == 4'd0);
    end
    lz_blank = (idx_q != 3'd0) && upper_zero[idx_q];
  end
`else
  // Every digit is decoded, zeros included.
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Output decode for the current phase; registered below.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    if (state_q == ST_SHOW) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = lz_blank ? 7'h7F : decode(digit_q[idx_q]);
    end
  end

  // Registered display pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign wr.wr_err = err_q;

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan with a cycle-indexed reference model:
// slot position and scan index come from plain arithmetic on the cycle
// count since reset, digits live in a simple array.
module tb_display_scan;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int NITER = 3000;

  logic       clock;
  logic       reset;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  display_scan_if wr_if ();

  display_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clock (clock),
    .reset (reset),
    .wr    (wr_if.slave),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference state
  int         m;
  int         mdig [8];
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_err;

  task automatic model_reset();
    m = 0;
    for (int i = 0; i < 8; i++) mdig[i] = 0;
    exp_an  = 8'hFF;
    exp_seg = 7'h7F;
    exp_err = 1'b0;
  endtask

  function automatic logic [6:0] model_seg(input int ix);
    bit dark;
    dark = 0;
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
    if (ix >= 1) begin
      dark = 1;
      for (int k = ix; k < 8; k++) if (mdig[k] != 0) dark = 0;
    end
`endif
    return dark ? 7'h7F : seg_tab[mdig[ix]];
  endfunction

  initial begin
    int   c, ix, pos, dig;
    bit   rdy, acc, hold, want_rst;
    logic [7:0] nxt_an;
    logic [6:0] nxt_seg;

    reset          = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_pos   = 4'd0;
    wr_if.wr_dig   = 4'd0;
    hold           = 0;
    want_rst       = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;

    for (int it = 0; it < NITER; it++) begin
      if (it % 700 == 350) want_rst = 1;
      c  = m % DIV;
      ix = (m / DIV) % 8;

      if (want_rst && c >= BLANK && m > DIV) begin
        // Reset mid-SHOW with a write in flight.
        want_rst       = 0;
        reset          = 1'b0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_pos   = 4'($urandom_range(0, 7));
        wr_if.wr_dig   = 4'($urandom_range(1, 9));
        #1;
        chk("rst_an",  32'(an),  32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_err", 32'(wr_if.wr_err), 32'h0);
        @(posedge clock);
        #1 wr_if.wr_valid = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        hold = 0;
        continue;
      end

      if (!hold) begin
        wr_if.wr_valid = ($urandom % 3) != 0;
        wr_if.wr_pos   = 4'($urandom_range(0, 9));
        wr_if.wr_dig   = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom_range(0, 11));
      end
      #3;
      pos = int'(wr_if.wr_pos);
      dig = int'(wr_if.wr_dig);

      rdy = !((c >= BLANK) && (pos == ix));
      chk("wr_ready", 32'(wr_if.wr_ready), 32'(rdy));
      chk("an",       32'(an),             32'(exp_an));
      chk("seg",      32'(seg),            32'(exp_seg));
      chk("wr_err",   32'(wr_if.wr_err),   32'(exp_err));
      chk("dp",       32'(dp),             32'h1);

      if (c < BLANK) begin
        nxt_an  = 8'hFF;
        nxt_seg = 7'h7F;
      end else begin
        nxt_an  = ~(8'(1) << ix);
        nxt_seg = model_seg(ix);
      end
      acc     = wr_if.wr_valid && rdy;
      exp_err = acc && (pos > 7 || dig > 9);
      if (acc && pos <= 7 && dig <= 9) mdig[pos] = dig;
      hold    = wr_if.wr_valid && !acc;
      exp_an  = nxt_an;
      exp_seg = nxt_seg;
      m++;

      @(posedge clock);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
